// File: rtl/int4_unit_pkg.sv
// Shared types for the INT4 pulse sequencer slice.
// Operand/product widths and sequencer state encoding.
package int4_unit_pkg;

  localparam int INT4_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PULSE_HI,
    PULSE_LO,
    SETTLE,
    READ,
    OUT
  } seq_state_t;

endpackage

// File: rtl/int4_pulse_seq_if.sv
// Operand and result handshake bundle of the INT4 sequencer.
// master drives operands/consumes results; slave is the sequencer.
interface int4_pulse_seq_if #(
  parameter int REG_SIZE = 16
) ();

  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_a;
  logic [3:0]          in_w;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [REG_SIZE-1:0] out_data;
  logic                out_ovf;
  logic                out_mismatch;

  modport master (
    output in_valid, in_a, in_w, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_ovf, out_mismatch
  );

  modport slave (
    input  in_valid, in_a, in_w, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_ovf, out_mismatch
  );

endinterface

// File: rtl/int4_pulse_timer.sv
// Loadable down-counter with zero flag.
// Times both the inter-pulse gap and the ripple settle window.
module int4_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/int4_pulse_seq.sv
// INT4 pulse sequencer: turns a*w into add_sig pulses for the
// ripple counter, then settles, unmasks and samples the count.
module int4_pulse_seq
  import int4_unit_pkg::*;
#(
  parameter int REG_SIZE   = 16,
  parameter int PULSE_GAP  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  int4_pulse_seq_if.slave     io,
  output logic                cnt_rst,
  output logic                add_sig,
  output logic                fsm_out_select,
  input  logic [REG_SIZE-1:0] cnt_value
);

  localparam int SH_W = REG_SIZE + 1;
  localparam int TMAX =
    (PULSE_GAP > SETTLE_CYC) ? PULSE_GAP : SETTLE_CYC;
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LD = TW'(PULSE_GAP - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYC - 1);
  localparam logic [SH_W-1:0] SH_MAX = '1;

  seq_state_t state_q, state_d;
  logic [PROD_W-1:0]   rem_q, rem_d;
  logic                last_q, last_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic                cnt_rst_q, cnt_rst_d;
  logic                add_q, add_d;
  logic                sel_q, sel_d;
  logic                rdy_q, rdy_d;
  logic                ov_q, ov_d;
  logic [REG_SIZE-1:0] od_q, od_d;
  logic                ovf_q, ovf_d;
  logic                mm_q, mm_d;

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic [PROD_W-1:0] prod;
  logic [SH_W:0]     sum;
  logic              accept;

  int4_pulse_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign prod = PROD_W'(io.in_a) * PROD_W'(io.in_w);
  assign sum = {1'b0, shadow_q} + (SH_W + 1)'(prod);
  assign accept = io.in_valid && rdy_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    od_d     = od_q;
    ovf_d    = ovf_q;
    mm_d     = mm_q;
    tmr_load = 1'b0;
    tmr_val  = GAP_LD;
    tmr_dec  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        shadow_d = '0;
        state_d  = IDLE;
      end
      IDLE: begin
        if (accept) begin
          rem_d  = prod;
          last_d = io.in_last;
          // Clamp instead of wrap so ovf can never clear itself
          shadow_d = sum[SH_W] ? SH_MAX : sum[SH_W-1:0];
          if (prod != '0) begin
            state_d = PULSE_HI;
          end else if (io.in_last) begin
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SET_LD;
          end
        end
      end
      PULSE_HI: begin
        rem_d    = rem_q - PROD_W'(1);
        state_d  = PULSE_LO;
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
      end
      PULSE_LO: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (rem_q != '0) begin
          state_d = PULSE_HI;
        end else if (last_q) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SET_LD;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (tmr_zero)
          state_d = READ;
        else
          tmr_dec = 1'b1;
      end
      READ: begin
        od_d    = cnt_value;
        ovf_d   = shadow_q[REG_SIZE];
        mm_d    = cnt_value != shadow_q[REG_SIZE-1:0];
        state_d = OUT;
      end
      OUT: begin
        if (io.out_ready)
          state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase

    cnt_rst_d = (state_d == CLEAR);
    add_d     = (state_d == PULSE_HI);
    rdy_d     = (state_d == IDLE);
    ov_d      = (state_d == OUT);
    sel_d     = !(state_d inside {SETTLE, READ, OUT});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      rem_q     <= '0;
      last_q    <= 1'b0;
      shadow_q  <= '0;
      cnt_rst_q <= 1'b1;
      add_q     <= 1'b0;
      sel_q     <= 1'b1;
      rdy_q     <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      ovf_q     <= 1'b0;
      mm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      last_q    <= last_d;
      shadow_q  <= shadow_d;
      cnt_rst_q <= cnt_rst_d;
      add_q     <= add_d;
      sel_q     <= sel_d;
      rdy_q     <= rdy_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      ovf_q     <= ovf_d;
      mm_q      <= mm_d;
    end
  end

  assign cnt_rst         = cnt_rst_q;
  assign add_sig         = add_q;
  assign fsm_out_select  = sel_q;
  assign io.in_ready     = rdy_q;
  assign io.out_valid    = ov_q;
  assign io.out_data     = od_q;
  assign io.out_ovf      = ovf_q;
  assign io.out_mismatch = mm_q;

endmodule

// File: tb/tb_int4_pulse_seq.sv
// Bench for int4_pulse_seq with a behavioural ripple counter.
// A REG_SIZE=8 copy shadows the 16-bit DUT for wrap checks.
module tb_int4_pulse_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int4_pulse_seq_if #(.REG_SIZE(16)) bus ();
  int4_pulse_seq_if #(.REG_SIZE(8))  bus8 ();

  logic        cr16, as16, sel16;
  logic [15:0] cv16;
  logic [15:0] cnt16 = '0;
  logic        cr8, as8, sel8;
  logic [7:0]  cv8;
  logic [7:0]  cnt8 = '0;

  int4_pulse_seq #(
    .REG_SIZE(16), .PULSE_GAP(1), .SETTLE_CYC(2)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (bus),
    .cnt_rst        (cr16),
    .add_sig        (as16),
    .fsm_out_select (sel16),
    .cnt_value      (cv16)
  );

  int4_pulse_seq #(
    .REG_SIZE(8), .PULSE_GAP(1), .SETTLE_CYC(2)
  ) u_dut8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .io             (bus8),
    .cnt_rst        (cr8),
    .add_sig        (as8),
    .fsm_out_select (sel8),
    .cnt_value      (cv8)
  );

  assign bus8.in_valid  = bus.in_valid;
  assign bus8.in_a      = bus.in_a;
  assign bus8.in_w      = bus.in_w;
  assign bus8.in_last   = bus.in_last;
  assign bus8.out_ready = bus.out_ready;

  // Ripple counter model: clears on cnt_rst, masked when selected
  always @(posedge clk) begin
    if (cr16) cnt16 <= '0;
    else if (as16) cnt16 <= cnt16 + 16'd1;
    if (cr8) cnt8 <= '0;
    else if (as8) cnt8 <= cnt8 + 8'd1;
  end
  assign cv16 = sel16 ? '0 : cnt16;
  assign cv8  = sel8 ? '0 : cnt8;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   npulse = 0;
  int   viol = 0;
  int   lat;
  logic add_prev = 1'b0;
  logic held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (as16 && (add_prev || cr16 || !sel16 || bus.in_ready))
      viol++;
    add_prev = as16;
    if (as16) npulse++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] a,
                      input logic [3:0] w,
                      input logic       l);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("in_rdy", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_w = w;
    bus.in_last = l;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    int t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("out_vld", 32'(bus.out_valid), 1);
    l = cyc - acc_cyc;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_w = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt_rst", 32'(cr16), 1);
    chk("rst_sel", 32'(sel16), 1);
    chk("rst_add", 32'(as16), 0);
    chk("rst_rdy", 32'(bus.in_ready), 0);
    chk("rst_ovld", 32'(bus.out_valid), 0);
    chk("rst_odata", 32'(bus.out_data), 0);
    chk("rst_ovf", 32'(bus.out_ovf), 0);
    chk("rst_mm", 32'(bus.out_mismatch), 0);
    rst_n = 1'b1;

    // 3*5: 15 pulses, 2-cycle period
    npulse = 0;
    send(4'd3, 4'd5, 1'b1);
    wait_out(lat);
    chk("t1_lat", 32'(lat), 33);
    chk("t1_np", 32'(npulse), 15);
    chk("t1_data", 32'(bus.out_data), 15);
    chk("t1_ovf", 32'(bus.out_ovf), 0);
    chk("t1_mm", 32'(bus.out_mismatch), 0);

    // accumulate three pairs
    npulse = 0;
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b0);
    send(4'd1, 4'd2, 1'b1);
    wait_out(lat);
    chk("t2_np", 32'(npulse), 452);
    chk("t2_data", 32'(bus.out_data), 452);
    chk("t2_ovf", 32'(bus.out_ovf), 0);
    chk("t2_mm", 32'(bus.out_mismatch), 0);
    chk("t2_d8", 32'(bus8.out_data), 196);
    chk("t2_ovf8", 32'(bus8.out_ovf), 1);

    // zero product
    npulse = 0;
    send(4'd0, 4'd9, 1'b1);
    wait_out(lat);
    chk("t3_lat", 32'(lat), 3);
    chk("t3_np", 32'(npulse), 0);
    chk("t3_data", 32'(bus.out_data), 0);

    // back-pressure on the result port
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(4'd2, 4'd3, 1'b1);
    wait_out(lat);
    chk("t4_lat", 32'(lat), 15);
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd6
          || sel16 !== 1'b0 || cr16 !== 1'b0)
        held = 1'b0;
    end
    chk("t4_hold", 32'(held), 1);
    chk("t4_data", 32'(bus.out_data), 6);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_hs_vld", 32'(bus.out_valid), 0);
    chk("t4_hs_crst", 32'(cr16), 1);
    chk("t4_hs_sel", 32'(sel16), 1);
    chk("t4_hs_rdy", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("t4_rdy", 32'(bus.in_ready), 1);
    chk("t4_crst", 32'(cr16), 0);

    // wrap on the 8-bit copy
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    wait_out(lat);
    chk("t5_d8", 32'(bus8.out_data), 194);
    chk("t5_ovf8", 32'(bus8.out_ovf), 1);
    chk("t5_mm8", 32'(bus8.out_mismatch), 0);
    chk("t5_d16", 32'(bus.out_data), 450);
    chk("t5_ovf16", 32'(bus.out_ovf), 0);

    // reset during PULSE_LO of 7*7
    send(4'd7, 4'd7, 1'b1);
    repeat (5) @(negedge clk);
    begin
      int t = 0;
      while (!as16 && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    chk("t6_hi", 32'(as16), 1);
    @(negedge clk);
    chk("t6_lo", 32'(as16), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_add", 32'(as16), 0);
    chk("t6_crst", 32'(cr16), 1);
    chk("t6_sel", 32'(sel16), 1);
    chk("t6_rdy", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    send(4'd2, 4'd2, 1'b1);
    wait_out(lat);
    chk("t6_np", 32'(npulse), 4);
    chk("t6_data", 32'(bus.out_data), 4);
    chk("t6_mm", 32'(bus.out_mismatch), 0);

    repeat (4) @(negedge clk);
    chk("add_rules", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
